l2_read_cache: RTL and testbench
================================

L2_READ_CACHE -- requirements
Module: l2_read_cache

Interface
REQ-001 SHALL have parameter INDEX_W, default 6, meaning index bits (2^INDEX_W direct-mapped 128-bit lines); tag width = 28-INDEX_W.
REQ-002 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-003 proc_reset_n  in  1  reset, synchronous, active-low.
REQ-004 l1_read  in  1  block read request from L1; held high until l1_ready seen.
REQ-005 l1_addr  in  28  block address, valid while l1_read high.
REQ-006 l1_rdata  out  128  returned block, valid only while l1_ready high.
REQ-007 l1_ready  out  1  single-cycle completion pulse to L1.
REQ-008 mem_read  out  1  block read request to main memory, held until mem_ready.
REQ-009 mem_addr  out  28  block address to main memory.
REQ-010 mem_rdata  in  128  main-memory block, valid while mem_ready high.
REQ-011 mem_ready  in  1  main-memory completion, one cycle.
REQ-012 hit_cnt  out  16  saturating count of L1 requests served as hits.
REQ-013 miss_cnt  out  16  saturating count of L1 requests served as misses.

Function
REQ-014 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-015 Address split SHALL be index = l1_addr[INDEX_W-1:0], tag = l1_addr[27:INDEX_W]; each line holds valid, tag, 128-bit data.
REQ-016 FSM states SHALL be IDLE, MISS, RESP.
REQ-017 IDLE: on l1_read=1, latch l1_addr; hit (valid and tag match) -> RESP with l1_rdata = stored line, hit_cnt+1; miss -> MISS with mem_read=1, mem_addr = latched address, miss_cnt+1.
REQ-018 Hit latency SHALL be exactly 1: l1_read sampled at edge N -> l1_ready high for the cycle after edge N+1... specifically l1_ready high in cycle following edge N, low after edge N+1.
REQ-019 MISS: hold mem_read and mem_addr stable; on mem_ready=1, write mem_rdata, latched tag and valid=1 into the latched index, clear mem_read, set l1_rdata = mem_rdata, go RESP.
REQ-020 Miss latency SHALL be mem latency + 2 cycles (request edge, mem_ready edge, then l1_ready).
REQ-021 RESP: l1_ready=1 for exactly one cycle, then IDLE with l1_ready=0; l1_read is ignored during RESP.
REQ-022 Changes on l1_addr while not in IDLE SHALL be ignored; the latched address is used.
REQ-023 mem_ready outside MISS SHALL be ignored and SHALL NOT modify any line.
REQ-024 l1_rdata SHALL hold its last value when l1_ready=0; content is don't-care for L1.
REQ-025 hit_cnt and miss_cnt SHALL saturate at 16'hFFFF, never wrap.
REQ-026 Line replacement SHALL be unconditional overwrite (read-only cache, no dirty state, no write-back).

Reset
REQ-027 proc_reset_n=0 at a rising edge SHALL set state IDLE, all valid bits 0, l1_ready=0, l1_rdata=0, mem_read=0, mem_addr=0, hit_cnt=0, miss_cnt=0.
REQ-028 Reset during MISS SHALL drop mem_read the following cycle and discard the pending fill; a later mem_ready SHALL be ignored.
REQ-029 Tag and data arrays need not be reset; only valid bits are.

Structure
REQ-030 Shared package l2_pkg SHALL hold the FSM state type, block address width (28), block data width (128), and counter width (16).
REQ-031 Line storage (valid/tag/data array, one read port, one write port) SHALL be a sub-module l2_line_store; FSM and counters stay in l2_read_cache.

Verification
REQ-032 Cold miss: after reset, l1_read addr 28'h0000040 -> mem_read=1, mem_addr=28'h0000040 next cycle; mem_ready with data 128'hA5.. after 3 cycles -> l1_ready one cycle later with that data, miss_cnt=1.
REQ-033 Hit: repeat read 28'h0000040 -> l1_ready exactly one cycle after request, same data, mem_read stays 0, hit_cnt=1.
REQ-034 Conflict: read 28'h0000080 (same index 0, different tag) -> miss, line replaced; then read 28'h0000040 -> miss again, miss_cnt=3.
REQ-035 Reset mid-miss: proc_reset_n low while in MISS, mem_ready arrives afterwards -> no l1_ready, mem_read 0, next read of same address misses.
REQ-036 Back-to-back: L1 re-asserts l1_read the cycle after l1_ready -> accepted in IDLE, no request lost or duplicated.
REQ-037 Saturation: force 65536+ hits -> hit_cnt stays 16'hFFFF.

Source files
------------

// File: rtl/l2_pkg.sv
// Shared types and widths for the L2 read-only block cache.
package l2_pkg;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MISS = 2'd1,
    RESP = 2'd2
  } state_t;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/l2_line_store.sv
// Direct-mapped line storage: valid/tag/data, one async read port, one write port.
module l2_line_store
  import l2_pkg::*;
#(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = ADDR_W - INDEX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [INDEX_W-1:0] rd_index,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES];

  // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays carry no reset; a cleared valid bit makes their contents irrelevant.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/l2_read_cache.sv
// Read-only direct-mapped L2 block cache between L1 and main memory, with hit/miss counters.
module l2_read_cache
  import l2_pkg::*;
#(
  parameter int INDEX_W = 6
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  input  logic              l1_read,
  input  logic [ADDR_W-1:0] l1_addr,
  output logic [DATA_W-1:0] l1_rdata,
  output logic              l1_ready,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int TAG_W = ADDR_W - INDEX_W;

  state_t            state, state_next;
  logic [ADDR_W-1:0] addr_q, addr_next;
  logic [DATA_W-1:0] rdata_next;
  logic              ready_next, mem_read_next, fill;
  logic [CNT_W-1:0]  hit_next, miss_next;

  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [DATA_W-1:0] rd_data;
  logic              lookup_hit;

  l2_line_store #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_store (
    .clk      (clk),
    .rst_n    (proc_reset_n),
    .rd_index (l1_addr[INDEX_W-1:0]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (fill && proc_reset_n),
    .wr_index (addr_q[INDEX_W-1:0]),
    .wr_tag   (addr_q[ADDR_W-1:INDEX_W]),
    .wr_data  (mem_rdata)
  );

  assign lookup_hit = rd_valid && (rd_tag == l1_addr[ADDR_W-1:INDEX_W]);

  // NOTE: every always_comb output is defaulted first so no path can infer a latch.
  always_comb begin
    state_next    = state;
    addr_next     = addr_q;
    rdata_next    = l1_rdata;
    ready_next    = 1'b0;
    mem_read_next = mem_read;
    hit_next      = hit_cnt;
    miss_next     = miss_cnt;
    fill          = 1'b0;
    case (state)
      IDLE: begin
        if (l1_read) begin
          addr_next = l1_addr;
          if (lookup_hit) begin
            rdata_next = rd_data;
            ready_next = 1'b1;
            hit_next   = sat_inc(hit_cnt);
            state_next = RESP;
          end else begin
            mem_read_next = 1'b1;
            miss_next     = sat_inc(miss_cnt);
            state_next    = MISS;
          end
        end
      end
      MISS: begin
        if (mem_ready) begin
          fill          = 1'b1;
          mem_read_next = 1'b0;
          rdata_next    = mem_rdata;
          ready_next    = 1'b1;
          state_next    = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!proc_reset_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      l1_rdata <= '0;
      l1_ready <= 1'b0;
      mem_read <= 1'b0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      state    <= state_next;
      addr_q   <= addr_next;
      l1_rdata <= rdata_next;
      l1_ready <= ready_next;
      mem_read <= mem_read_next;
      hit_cnt  <= hit_next;
      miss_cnt <= miss_next;
    end
  end

  // The latched request address doubles as the memory request address.
  assign mem_addr = addr_q;

endmodule

// File: tb/tb_l2_read_cache.sv
// Self-checking bench for l2_read_cache: directed scenarios plus random reads against a line model.
module tb_l2_read_cache;

  localparam int INDEX_W = 6;

  logic         clk = 1'b0;
  logic         proc_reset_n;
  logic         l1_read;
  logic [27:0]  l1_addr;
  logic [127:0] l1_rdata;
  logic         l1_ready;
  logic         mem_read;
  logic [27:0]  mem_addr;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  logic [15:0]  hit_cnt;
  logic [15:0]  miss_cnt;

  always #5 clk = ~clk;

  l2_read_cache #(.INDEX_W(INDEX_W)) dut (
    .clk          (clk),
    .proc_reset_n (proc_reset_n),
    .l1_read      (l1_read),
    .l1_addr      (l1_addr),
    .l1_rdata     (l1_rdata),
    .l1_ready     (l1_ready),
    .mem_read     (mem_read),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: which full block address each index currently holds, and its data.
  logic [27:0]  m_addr [int];
  logic [127:0] m_data [int];
  logic [15:0]  m_hit, m_miss;

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic int index_of(input logic [27:0] a);
    return int'(a) % (1 << INDEX_W);
  endfunction

  function automatic bit model_hit(input logic [27:0] a);
    int idx = index_of(a);
    return m_addr.exists(idx) && (m_addr[idx] == a);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    m_addr.delete();
    m_data.delete();
    m_hit  = 16'd0;
    m_miss = 16'd0;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    check(tag, {127'd0, obs}, {127'd0, exp});
  endtask

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    check(tag, {112'd0, obs}, {112'd0, exp});
  endtask

  task automatic check28(input string tag, input logic [27:0] obs, input logic [27:0] exp);
    check(tag, {100'd0, obs}, {100'd0, exp});
  endtask

  // Called just after a negedge; returns just after the negedge where l1_ready must be low again.
  task automatic do_read(input logic [27:0] a, input int lat, input logic [127:0] fill_data);
    int idx = index_of(a);
    bit hit = model_hit(a);
    l1_read = 1'b1;
    l1_addr = a;
    @(negedge clk);
    if (hit) begin
      m_hit = sat(m_hit);
      check1("hit_ready", l1_ready, 1'b1);
      check("hit_data", l1_rdata, m_data[idx]);
      check1("hit_no_mem_read", mem_read, 1'b0);
      check16("hit_cnt", hit_cnt, m_hit);
      check16("hit_miss_cnt", miss_cnt, m_miss);
    end else begin
      m_miss = sat(m_miss);
      check1("miss_mem_read", mem_read, 1'b1);
      check28("miss_mem_addr", mem_addr, a);
      check1("miss_no_ready", l1_ready, 1'b0);
      check16("miss_cnt", miss_cnt, m_miss);
      check16("miss_hit_cnt", hit_cnt, m_hit);
      l1_addr = 28'($urandom);
      repeat (lat) @(negedge clk);
      check1("miss_hold_read", mem_read, 1'b1);
      check28("miss_hold_addr", mem_addr, a);
      check1("miss_wait_ready", l1_ready, 1'b0);
      mem_ready = 1'b1;
      mem_rdata = fill_data;
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = rand128();
      m_addr[idx] = a;
      m_data[idx] = fill_data;
      check1("fill_ready", l1_ready, 1'b1);
      check("fill_data", l1_rdata, fill_data);
      check1("fill_mem_read_drop", mem_read, 1'b0);
    end
    l1_read = 1'b0;
    l1_addr = 28'($urandom);
    // A stray mem_ready during RESP must not touch any line.
    if ($urandom_range(0, 1) == 1) begin
      mem_ready = 1'b1;
      mem_rdata = rand128();
    end
    @(negedge clk);
    mem_ready = 1'b0;
    check1("ready_one_cycle", l1_ready, 1'b0);
  endtask

  task automatic stray_mem_ready();
    mem_ready = 1'b1;
    mem_rdata = rand128();
    @(negedge clk);
    mem_ready = 1'b0;
    check1("stray_no_ready", l1_ready, 1'b0);
    check1("stray_no_mem_read", mem_read, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [27:0]  a;
    logic [27:0]  last_a;
    logic [127:0] pat_a5;

    proc_reset_n = 1'b0;
    l1_read      = 1'b0;
    l1_addr      = '0;
    mem_rdata    = '0;
    mem_ready    = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);

    check1("rst_l1_ready", l1_ready, 1'b0);
    check("rst_l1_rdata", l1_rdata, 128'd0);
    check1("rst_mem_read", mem_read, 1'b0);
    check28("rst_mem_addr", mem_addr, 28'd0);
    check16("rst_hit_cnt", hit_cnt, 16'd0);
    check16("rst_miss_cnt", miss_cnt, 16'd0);
    proc_reset_n = 1'b1;
    @(negedge clk);

    // Cold miss with a 3-cycle memory, then a hit on the same block.
    pat_a5 = {16{8'hA5}};
    do_read(28'h0000040, 3, pat_a5);
    check16("cold_miss_cnt", miss_cnt, 16'd1);
    do_read(28'h0000040, 0, rand128());
    check16("hit_cnt_one", hit_cnt, 16'd1);

    // Same index, different tag: each evicts the other.
    do_read(28'h0000080, 2, rand128());
    do_read(28'h0000040, 1, rand128());
    check16("conflict_miss_cnt", miss_cnt, 16'd3);

    stray_mem_ready();
    do_read(28'h0000040, 0, rand128());

    // Reset while the miss is outstanding; the late fill must be discarded.
    l1_read = 1'b1;
    l1_addr = 28'h0000123;
    @(negedge clk);
    check1("rm_mem_read", mem_read, 1'b1);
    l1_read      = 1'b0;
    proc_reset_n = 1'b0;
    @(negedge clk);
    proc_reset_n = 1'b1;
    model_reset();
    check1("rm_mem_read_drop", mem_read, 1'b0);
    check1("rm_no_ready", l1_ready, 1'b0);
    check16("rm_miss_cnt", miss_cnt, 16'd0);
    mem_ready = 1'b1;
    mem_rdata = rand128();
    @(negedge clk);
    mem_ready = 1'b0;
    check1("rm_late_fill_no_ready", l1_ready, 1'b0);
    check1("rm_late_fill_mem_read", mem_read, 1'b0);
    do_read(28'h0000123, 1, rand128());
    check16("rm_refetch_miss", miss_cnt, 16'd1);

    // Random back-to-back traffic over a few tags on a few indices.
    last_a = 28'h0000123;
    for (int i = 0; i < 400; i++) begin
      a = 28'(($urandom_range(0, 3) << INDEX_W) | $urandom_range(0, 7));
      do_read(a, int'($urandom_range(0, 4)), rand128());
      last_a = a;
      if ($urandom_range(0, 9) == 0) stray_mem_ready();
    end

    // Preload the hit counter near its ceiling, then keep hitting.
    force dut.hit_cnt = 16'hFFFC;
    @(negedge clk);
    release dut.hit_cnt;
    m_hit = 16'hFFFC;
    for (int i = 0; i < 6; i++) do_read(last_a, 0, rand128());
    check16("hit_cnt_saturated", hit_cnt, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
